// File: rtl/stage4_integration_pkg.sv
// rtl/stage4_integration_pkg.sv - shared opcodes, FSM states and select encodings
package stage4_integration_pkg;

    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_ASR   = 4'b1010;
    localparam logic [3:0] OP_PUSHI = 4'b1011;
    localparam logic [3:0] OP_JUMP  = 4'b1100;
    localparam logic [3:0] OP_BRZ   = 4'b1101;
    localparam logic [3:0] OP_CALL  = 4'b1110;
    localparam logic [3:0] OP_RET   = 4'b1111;

    typedef enum logic [4:0] {
        ST_RESET  = 5'd0,
        ST_FETCH  = 5'd1,
        ST_DECODE = 5'd2,
        ST_ALU    = 5'd3,
        ST_SHIFT  = 5'd4,
        ST_WB     = 5'd5,
        ST_PUSHI  = 5'd6,
        ST_JUMP   = 5'd7,
        ST_BRZ    = 5'd8,
        ST_CALL   = 5'd9,
        ST_RET    = 5'd10,
        ST_RET2   = 5'd11
    } state_t;

    localparam logic [1:0] MEMDST_PC     = 2'b00;
    localparam logic [1:0] MEMDST_MSP    = 2'b01;
    localparam logic [1:0] MEMDST_MSP_M1 = 2'b10;
    localparam logic [1:0] MEMDST_RSP    = 2'b11;

    localparam logic [2:0] MEMDATA_RES  = 3'b000;
    localparam logic [2:0] MEMDATA_VALA = 3'b001;
    localparam logic [2:0] MEMDATA_PC   = 3'b010;
    localparam logic [2:0] MEMDATA_SEXT = 3'b011;
    localparam logic [2:0] MEMDATA_ZEXT = 3'b100;

    // Opcodes 1000..1010 are the three immediate shifts.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/stage4_integration_control_fsm.sv
// rtl/stage4_integration_control_fsm.sv - multicycle control FSM for the stack CPU
module control_fsm
    import stage4_integration_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       is_zero,
    output logic       pc_source,
    output logic       pc_write,
    output logic       pc_add,
    output logic       msp_pop,
    output logic       msp_write,
    output logic       rsp_pop,
    output logic       rsp_write,
    output logic       ir_write,
    output logic       vala_write,
    output logic       valb_write,
    output logic       res_source,
    output logic       res_write,
    output logic [1:0] mem_dst1,
    output logic [1:0] mem_dst2,
    output logic [2:0] mem_data,
    output logic       mem_write1,
    output logic       mem_write2,
    output logic       mem_read1,
    output logic       mem_read2,
    output logic [2:0] alu_op
);

    state_t state_q;
    state_t state_d;

    // State register; reset wins over any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    // Next-state sequencing; DECODE dispatches on the opcode.
    always_comb begin
        state_d = ST_RESET;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (!opcode[3])               state_d = ST_ALU;
                else if (is_shift_op(opcode)) state_d = ST_SHIFT;
                else begin
                    case (opcode)
                        OP_PUSHI: state_d = ST_PUSHI;
                        OP_JUMP:  state_d = ST_JUMP;
                        OP_BRZ:   state_d = ST_BRZ;
                        OP_CALL:  state_d = ST_CALL;
                        default:  state_d = ST_RET;
                    endcase
                end
            end
            ST_ALU:    state_d = ST_WB;
            ST_SHIFT:  state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_PUSHI:  state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_BRZ:    state_d = ST_FETCH;
            ST_CALL:   state_d = ST_FETCH;
            ST_RET:    state_d = ST_RET2;
            ST_RET2:   state_d = ST_FETCH;
            default:   state_d = ST_RESET;
        endcase
    end

    // Moore strobe decode; ALUop follows the opcode and BRZ gates PCWrite by the zero flag.
    always_comb begin
        pc_source  = 1'b0;
        pc_write   = 1'b0;
        pc_add     = 1'b0;
        msp_pop    = 1'b0;
        msp_write  = 1'b0;
        rsp_pop    = 1'b0;
        rsp_write  = 1'b0;
        ir_write   = 1'b0;
        vala_write = 1'b0;
        valb_write = 1'b0;
        res_source = 1'b0;
        res_write  = 1'b0;
        mem_dst1   = MEMDST_PC;
        mem_dst2   = MEMDST_PC;
        mem_data   = MEMDATA_RES;
        mem_write1 = 1'b0;
        mem_write2 = 1'b0;
        mem_read1  = 1'b0;
        mem_read2  = 1'b0;
        alu_op     = 3'b000;
        case (state_q)
            ST_FETCH: begin
                mem_read1 = 1'b1;
                mem_dst1  = MEMDST_PC;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                pc_add    = 1'b1;
            end
            ST_DECODE: begin
                mem_read1  = 1'b1;
                mem_dst1   = MEMDST_MSP;
                mem_read2  = 1'b1;
                mem_dst2   = MEMDST_MSP_M1;
                vala_write = 1'b1;
                valb_write = 1'b1;
            end
            ST_ALU: begin
                alu_op    = opcode[2:0];
                res_write = 1'b1;
                msp_pop   = 1'b1;
            end
            ST_SHIFT: begin
                res_source = 1'b1;
                res_write  = 1'b1;
            end
            ST_WB: begin
                mem_write1 = 1'b1;
                mem_dst1   = MEMDST_MSP;
                mem_data   = MEMDATA_RES;
                msp_write  = 1'b1;
            end
            ST_PUSHI: begin
                mem_write1 = 1'b1;
                mem_dst1   = MEMDST_MSP;
                mem_data   = MEMDATA_SEXT;
                msp_write  = 1'b1;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
            end
            ST_BRZ: begin
                pc_write = is_zero;
                msp_pop  = 1'b1;
            end
            ST_CALL: begin
                mem_write2 = 1'b1;
                mem_dst2   = MEMDST_RSP;
                mem_data   = MEMDATA_PC;
                rsp_write  = 1'b1;
                pc_write   = 1'b1;
            end
            ST_RET: begin
                mem_read1  = 1'b1;
                mem_dst1   = MEMDST_RSP;
                vala_write = 1'b1;
                rsp_pop    = 1'b1;
            end
            ST_RET2: begin
                pc_source = 1'b1;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage4_integration_imm_shifter.sv
// rtl/stage4_integration_imm_shifter.sv - immediate barrel shifter and extenders
module imm_shifter
    import stage4_integration_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] shift_in,
    output logic [15:0] shift_out,
    output logic [15:0] zext_out,
    output logic [15:0] sext_out
);

    logic        amt_big;
    logic [3:0]  amt;
    logic [15:0] shl_res;
    logic [15:0] shr_res;
    logic [15:0] asr_res;

    // Twelve-bit amount: anything with bits above bit 3 set is a full-width shift.
    always_comb begin
        amt_big  = |ir[11:4];
        amt      = ir[3:0];
        shl_res  = amt_big ? 16'h0000 : (shift_in << amt);
        shr_res  = amt_big ? 16'h0000 : (shift_in >> amt);
        asr_res  = amt_big ? {16{shift_in[15]}} : 16'($signed(shift_in) >>> amt);
        zext_out = {4'b0000, ir[11:0]};
        sext_out = {{4{ir[11]}}, ir[11:0]};
        case (ir[15:12])
            OP_SHL:  shift_out = shl_res;
            OP_SHR:  shift_out = shr_res;
            OP_ASR:  shift_out = asr_res;
            default: shift_out = shift_in;
        endcase
    end

endmodule

// File: rtl/stage4_integration.sv
// rtl/stage4_integration.sv - stage-4 top wiring immediate datapath and control FSM
module stage4_integration
    import stage4_integration_pkg::*;
(
    input  logic        CLK,
    input  logic        CtrlRst,
    input  logic [15:0] IROut,
    input  logic        isZero,
    input  logic [15:0] ShifterIn,
    output logic [15:0] ShifterOut,
    output logic [15:0] ZeroExtOut,
    output logic [15:0] SignExtOut,
    output logic        PCSource,
    output logic        PCWrite,
    output logic        PCAdd,
    output logic        MSPPop,
    output logic        MSPWrite,
    output logic        RSPPop,
    output logic        RSPWrite,
    output logic        IRWrite,
    output logic        ValAWrite,
    output logic        ValBWrite,
    output logic        ResSource,
    output logic        ResWrite,
    output logic [1:0]  MemDst1,
    output logic [1:0]  MemDst2,
    output logic [2:0]  MemData,
    output logic        MemWrite1,
    output logic        MemWrite2,
    output logic        MemRead1,
    output logic        MemRead2,
    output logic [2:0]  ALUop
);

    imm_shifter u_imm_shifter (
        .ir        (IROut),
        .shift_in  (ShifterIn),
        .shift_out (ShifterOut),
        .zext_out  (ZeroExtOut),
        .sext_out  (SignExtOut)
    );

    control_fsm u_control_fsm (
        .clk        (CLK),
        .rst        (CtrlRst),
        .opcode     (IROut[15:12]),
        .is_zero    (isZero),
        .pc_source  (PCSource),
        .pc_write   (PCWrite),
        .pc_add     (PCAdd),
        .msp_pop    (MSPPop),
        .msp_write  (MSPWrite),
        .rsp_pop    (RSPPop),
        .rsp_write  (RSPWrite),
        .ir_write   (IRWrite),
        .vala_write (ValAWrite),
        .valb_write (ValBWrite),
        .res_source (ResSource),
        .res_write  (ResWrite),
        .mem_dst1   (MemDst1),
        .mem_dst2   (MemDst2),
        .mem_data   (MemData),
        .mem_write1 (MemWrite1),
        .mem_write2 (MemWrite2),
        .mem_read1  (MemRead1),
        .mem_read2  (MemRead2),
        .alu_op     (ALUop)
    );

endmodule

// File: tb/tb_stage4_integration.sv
// tb/tb_stage4_integration.sv - scoreboard bench for stage4_integration
module tb_stage4_integration;

    logic        CLK = 1'b0;
    logic        CtrlRst = 1'b1;
    logic [15:0] IROut = 16'h0000;
    logic        isZero = 1'b0;
    logic [15:0] ShifterIn = 16'h0000;
    logic [15:0] ShifterOut, ZeroExtOut, SignExtOut;
    logic        PCSource, PCWrite, PCAdd, MSPPop, MSPWrite, RSPPop, RSPWrite;
    logic        IRWrite, ValAWrite, ValBWrite, ResSource, ResWrite;
    logic [1:0]  MemDst1, MemDst2;
    logic [2:0]  MemData, ALUop;
    logic        MemWrite1, MemWrite2, MemRead1, MemRead2;

    int errors = 0;
    int checks = 0;

    localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_ALU = 3, S_SHIFT = 4, S_WB = 5,
                   S_PUSHI = 6, S_JUMP = 7, S_BRZ = 8, S_CALL = 9, S_RET = 10, S_RET2 = 11;

    typedef struct {
        int          st;
        logic [25:0] ctrl;
    } fsm_exp_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] sin;
        logic [15:0] sh;
        logic [15:0] z;
        logic [15:0] s;
    } imm_exp_t;

    fsm_exp_t fsm_q[$];
    imm_exp_t imm_q[$];

    stage4_integration dut (
        .CLK(CLK), .CtrlRst(CtrlRst), .IROut(IROut), .isZero(isZero), .ShifterIn(ShifterIn),
        .ShifterOut(ShifterOut), .ZeroExtOut(ZeroExtOut), .SignExtOut(SignExtOut),
        .PCSource(PCSource), .PCWrite(PCWrite), .PCAdd(PCAdd), .MSPPop(MSPPop),
        .MSPWrite(MSPWrite), .RSPPop(RSPPop), .RSPWrite(RSPWrite), .IRWrite(IRWrite),
        .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .ResSource(ResSource),
        .ResWrite(ResWrite), .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
        .MemWrite1(MemWrite1), .MemWrite2(MemWrite2), .MemRead1(MemRead1),
        .MemRead2(MemRead2), .ALUop(ALUop)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Field order: PCSource PCWrite PCAdd MSPPop MSPWrite RSPPop RSPWrite IRWrite ValAWrite
    // ValBWrite ResSource ResWrite MemDst1 MemDst2 MemData MemWrite1 MemWrite2 MemRead1 MemRead2 ALUop
    function automatic logic [25:0] ctrl_of(input int st, input logic [15:0] ir, input logic iz);
        logic pcs, pcw, pca, mpop, mwr, rpop, rwr, irw, vaw, vbw, rs, rsw, mw1, mw2, mr1, mr2;
        logic [1:0] d1, d2;
        logic [2:0] md, aop;
        {pcs, pcw, pca, mpop, mwr, rpop, rwr, irw, vaw, vbw, rs, rsw, mw1, mw2, mr1, mr2} = '0;
        d1 = 2'b00; d2 = 2'b00; md = 3'b000; aop = 3'b000;
        case (st)
            S_FETCH:  begin mr1 = 1; d1 = 2'b00; irw = 1; pcw = 1; pca = 1; end
            S_DECODE: begin mr1 = 1; d1 = 2'b01; mr2 = 1; d2 = 2'b10; vaw = 1; vbw = 1; end
            S_ALU:    begin aop = ir[14:12]; rsw = 1; mpop = 1; end
            S_SHIFT:  begin rs = 1; rsw = 1; end
            S_WB:     begin mw1 = 1; d1 = 2'b01; md = 3'b000; mwr = 1; end
            S_PUSHI:  begin mw1 = 1; d1 = 2'b01; md = 3'b011; mwr = 1; end
            S_JUMP:   begin pcw = 1; end
            S_BRZ:    begin pcw = iz; mpop = 1; end
            S_CALL:   begin mw2 = 1; d2 = 2'b11; md = 3'b010; rwr = 1; pcw = 1; end
            S_RET:    begin mr1 = 1; d1 = 2'b11; vaw = 1; rpop = 1; end
            S_RET2:   begin pcs = 1; pcw = 1; end
            default:  ;
        endcase
        return {pcs, pcw, pca, mpop, mwr, rpop, rwr, irw, vaw, vbw, rs, rsw, d1, d2, md,
                mw1, mw2, mr1, mr2, aop};
    endfunction

    function automatic logic [25:0] dut_ctrl();
        return {PCSource, PCWrite, PCAdd, MSPPop, MSPWrite, RSPPop, RSPWrite, IRWrite, ValAWrite,
                ValBWrite, ResSource, ResWrite, MemDst1, MemDst2, MemData, MemWrite1, MemWrite2,
                MemRead1, MemRead2, ALUop};
    endfunction

    task automatic push_state(input int st);
        fsm_exp_t e;
        e.st = st;
        e.ctrl = ctrl_of(st, IROut, isZero);
        fsm_q.push_back(e);
    endtask

    // One check per falling edge for every queued expectation.
    task automatic drain_fsm(input string name);
        fsm_exp_t e;
        while (fsm_q.size() > 0) begin
            @(negedge CLK);
            e = fsm_q.pop_front();
            check_eq($sformatf("%s_st%0d", name, e.st), 32'(dut_ctrl()), 32'(e.ctrl));
        end
    endtask

    task automatic run_instr(input string name, input logic [15:0] ir, input logic iz, input int exec_states[$]);
        IROut = ir;
        isZero = iz;
        push_state(S_FETCH);
        push_state(S_DECODE);
        foreach (exec_states[i]) push_state(exec_states[i]);
        drain_fsm(name);
    endtask

    task automatic imm_case(input logic [15:0] ir, input logic [15:0] sin,
                            input logic [15:0] sh, input logic [15:0] z, input logic [15:0] s);
        imm_exp_t e;
        IROut = ir;
        ShifterIn = sin;
        e.ir = ir; e.sin = sin; e.sh = sh; e.z = z; e.s = s;
        imm_q.push_back(e);
        #1;
        e = imm_q.pop_front();
        check_eq($sformatf("shift_%h_%h", e.ir, e.sin), 32'(ShifterOut), 32'(e.sh));
        check_eq($sformatf("zext_%h", e.ir), 32'(ZeroExtOut), 32'(e.z));
        check_eq($sformatf("sext_%h", e.ir), 32'(SignExtOut), 32'(e.s));
    endtask

    initial begin
        int seq[$];

        // Combinational immediate datapath, held in reset meanwhile.
        imm_case(16'h8003, 16'hFFF0, 16'hFF80, 16'h0003, 16'h0003);
        imm_case(16'h9004, 16'hFF00, 16'h0FF0, 16'h0004, 16'h0004);
        imm_case(16'hA004, 16'h8000, 16'hF800, 16'h0004, 16'h0004);
        imm_case(16'hA010, 16'h8000, 16'hFFFF, 16'h0010, 16'h0010);
        imm_case(16'hA010, 16'h7FFF, 16'h0000, 16'h0010, 16'h0010);
        imm_case(16'h8800, 16'h1234, 16'h0000, 16'h0800, 16'hF800);
        imm_case(16'h900F, 16'h8000, 16'h0001, 16'h000F, 16'h000F);
        imm_case(16'h8000, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000);
        imm_case(16'hBFFF, 16'h1357, 16'h1357, 16'h0FFF, 16'hFFFF);

        // Reset state.
        IROut = 16'h0001;
        repeat (2) @(posedge CLK);
        push_state(S_RESET);
        drain_fsm("reset");
        CtrlRst = 1'b0;

        seq = '{S_ALU, S_WB};           run_instr("alu_0001", 16'h0001, 1'b0, seq);
        seq = '{S_ALU, S_WB};           run_instr("alu_7000", 16'h7000, 1'b0, seq);
        seq = '{S_SHIFT, S_WB};         run_instr("shl", 16'h8003, 1'b0, seq);
        seq = '{S_SHIFT, S_WB};         run_instr("shr", 16'h9001, 1'b0, seq);
        seq = '{S_SHIFT, S_WB};         run_instr("asr", 16'hA002, 1'b0, seq);
        seq = '{S_PUSHI};               run_instr("pushi", 16'hB123, 1'b0, seq);
        seq = '{S_JUMP};                run_instr("jump", 16'hC010, 1'b0, seq);
        seq = '{S_BRZ};                 run_instr("brz_z1", 16'hD005, 1'b1, seq);
        seq = '{S_BRZ};                 run_instr("brz_z0", 16'hD005, 1'b0, seq);
        seq = '{S_CALL};                run_instr("call", 16'hE040, 1'b0, seq);
        seq = '{S_RET, S_RET2};         run_instr("ret", 16'hF000, 1'b0, seq);

        // Reset in the middle of an ALU instruction.
        seq = '{S_ALU};                 run_instr("alu_mid", 16'h0001, 1'b0, seq);
        CtrlRst = 1'b1;
        push_state(S_RESET);
        drain_fsm("mid_reset");
        CtrlRst = 1'b0;
        seq = '{S_SHIFT, S_WB};         run_instr("after_rst", 16'h8001, 1'b0, seq);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
